dmem_preload_ctrl: RTL
======================

Name: dmem_preload_ctrl

Overview:
- Synthesizable successor to bench-side data-memory preload and cycle counting for the rv32i core.
- Accepts a segmented word stream over valid/ready and writes each segment into data memory at a stream-supplied base address.
- Holds the core in reset until loading completes, then counts run cycles until the core signals halt.
- Sits between the host/ROM stream source and the core_top data-memory write port and core reset.

Parameters:
ADDR_W, 10, data-memory word-address width; addresses wrap modulo 2^ADDR_W
DATA_W, 32, data word width (≥ 16 + ADDR_W, since headers pack count and base)
SEG_MAX, 4, maximum segments per load; the load ends after SEG_MAX segments even without a terminator
CYC_W, 32, cycle counter width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse: restart loading (honoured only in RUN/HALTED)
s_valid  input  1  stream word valid
s_ready  output  1  stream word accepted when s_valid&&s_ready
s_data  input  DATA_W  header or payload word
mem_we  output  1  data-memory write enable (registered)
mem_addr  output  ADDR_W  data-memory word address (registered)
mem_wdata  output  DATA_W  data-memory write data (registered)
core_hold  output  1  active-high reset to core (registered)
halt  input  1  core finished
halted  output  1  run complete, cycles frozen
cycles  output  CYC_W  run cycle count
seg_count  output  3  segments loaded in current load (saturates at SEG_MAX)
wrap_err  output  1  sticky: a segment wrapped past address 2^ADDR_W-1

Behaviour:
- States: LOAD_HDR, LOAD_DATA, RUN, HALTED.
- Reset (synchronous, any state, including mid-segment): state=LOAD_HDR; mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, halted=0, cycles=0, seg_count=0, wrap_err=0; internal remain and ptr=0. While reset is high, s_ready=0.
- s_ready is combinational: (state==LOAD_HDR || state==LOAD_DATA) && !reset.
- Header word: count = s_data[31:16]; base = s_data[ADDR_W-1:0].
- LOAD_HDR, on handshake:
  - count==0: terminator. Go to RUN.
  - count!=0: ptr=base, remain=count. Go to LOAD_DATA.
- LOAD_DATA, on handshake:
  - Next edge: mem_we=1, mem_addr=ptr, mem_wdata=s_data. Write latency is 1 cycle from handshake.
  - ptr=ptr+1 mod 2^ADDR_W. If ptr was all-ones and remain>1, set wrap_err.
  - remain decrements.
  - On the last word (remain==1): seg_count+1. If the new seg_count==SEG_MAX, go to RUN; else go to LOAD_HDR.
- mem_we is 0 in every cycle without a data handshake in the prior cycle. Bubbles on s_valid produce no writes.
- core_hold is 1 in LOAD_HDR, LOAD_DATA and HALTED, and 0 in RUN. It is registered alongside the state, so it falls on the same edge the state becomes RUN.
- RUN:
  - cycles increments each cycle where halt=0; it saturates at all-ones.
  - When halt=1 is sampled: cycles does not increment that cycle, go to HALTED, halted=1.
- HALTED: cycles and halted hold.
- start in RUN or HALTED: go to LOAD_HDR; core_hold=1, cycles=0, halted=0, seg_count=0. wrap_err is kept (cleared only by reset). start takes priority over halt in the same cycle.
- start in LOAD_HDR or LOAD_DATA is ignored.
- Payload words are never interpreted as headers. A data-phase word with bits [31:16]=0 is written normally.

Test Plan:
- Message load. Stream 0x00030064, 0x68656c6c, 0x6f20776f, 0x726c6480, 0x00010073, 0x00000058, 0x00000000 with s_valid held high. Required: writes to addr 100/101/102/115 with those values, each 1 cycle after its handshake; seg_count=2; core_hold falls the cycle after the terminator handshake.
- Cycle count. After the above, hold halt=0 for 5 RUN cycles, then halt=1. Required: cycles=5, halted=1, core_hold=1; cycles stays 5 for 10 more cycles.
- Wrap. Header 0x000203FF (ADDR_W=10), then 0xA, 0xB. Required: writes at 1023 then 0; wrap_err=1 and sticky across start; cleared only by reset.
- SEG_MAX termination. Four headers of count 1 (bases 0,1,2,3), no terminator. Required: RUN entered after the 4th payload word; s_ready=0 afterwards; seg_count=4.
- Back-pressure and reset. Toggle s_valid every other cycle mid-segment: no mem_we in gap cycles. Assert reset after 1 of 3 payload words: all outputs return to reset values next cycle; the next accepted word is parsed as a header.
- Saturation and restart. With CYC_W=4, run 20 cycles: cycles=15, held. Then pulse start together with halt=1: state LOAD_HDR, cycles=0, halted=0, core_hold=1.

Source files
------------

// File: rtl/dmem_preload_ctrl.sv
// Purpose: load segmented word stream into data memory, hold core in reset, then count run cycles to halt.
// Latency: memory write appears 1 cycle after each payload handshake; core_hold changes with the state.
// Backpressure: s_ready is high only while loading; bubbles on s_valid simply stall the load.
module dmem_preload_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int SEG_MAX = 4,
  parameter int CYC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  input  logic              halt,
  output logic              halted,
  output logic [CYC_W-1:0]  cycles,
  output logic [2:0]        seg_count,
  output logic              wrap_err
);

  // Header layout: segment word count in the upper half, base address in the low bits.
  localparam int CNT_W = DATA_W - 16;

  typedef enum logic [1:0] {LOAD_HDR, LOAD_DATA, RUN, HALTED} state_t;

  state_t              state, state_nxt;
  logic                mem_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt;
  logic                core_hold_nxt;
  logic                halted_nxt;
  logic [CYC_W-1:0]    cycles_nxt;
  logic [2:0]          seg_count_nxt;
  logic                wrap_err_nxt;
  logic [CNT_W-1:0]    remain, remain_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt;

  logic                hs;
  logic [CNT_W-1:0]    hdr_cnt;
  logic [ADDR_W-1:0]   hdr_base;
  logic [2:0]          seg_inc;

  assign s_ready  = ((state == LOAD_HDR) || (state == LOAD_DATA)) && !reset;
  assign hs       = s_valid && s_ready;
  assign hdr_cnt  = s_data[DATA_W-1:16];
  assign hdr_base = s_data[ADDR_W-1:0];
  assign seg_inc  = seg_count + 3'd1;

  // Next-state and next-output logic; everything defaults to holding except the write strobe.
  always_comb begin
    state_nxt     = state;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    halted_nxt    = halted;
    cycles_nxt    = cycles;
    seg_count_nxt = seg_count;
    wrap_err_nxt  = wrap_err;
    remain_nxt    = remain;
    ptr_nxt       = ptr;

    case (state)
      LOAD_HDR: begin
        if (hs) begin
          if (hdr_cnt == '0) begin
            // Zero-count header terminates the load early.
            state_nxt = RUN;
          end else begin
            ptr_nxt    = hdr_base;
            remain_nxt = hdr_cnt;
            state_nxt  = LOAD_DATA;
          end
        end
      end

      LOAD_DATA: begin
        if (hs) begin
          mem_we_nxt    = 1'b1;
          mem_addr_nxt  = ptr;
          mem_wdata_nxt = s_data;
          ptr_nxt       = ptr + ADDR_W'(1);
          // Flag a segment that runs off the top of memory and continues at 0.
          if ((&ptr) && (remain > CNT_W'(1))) begin
            wrap_err_nxt = 1'b1;
          end
          remain_nxt = remain - CNT_W'(1);
          if (remain == CNT_W'(1)) begin
            seg_count_nxt = seg_inc;
            state_nxt     = (seg_inc == 3'(SEG_MAX)) ? RUN : LOAD_HDR;
          end
        end
      end

      RUN: begin
        // start wins over halt so a restart is never lost.
        if (start) begin
          state_nxt     = LOAD_HDR;
          cycles_nxt    = '0;
          halted_nxt    = 1'b0;
          seg_count_nxt = '0;
        end else if (halt) begin
          state_nxt  = HALTED;
          halted_nxt = 1'b1;
        end else if (!(&cycles)) begin
          cycles_nxt = cycles + CYC_W'(1);
        end
      end

      HALTED: begin
        if (start) begin
          state_nxt     = LOAD_HDR;
          cycles_nxt    = '0;
          halted_nxt    = 1'b0;
          seg_count_nxt = '0;
        end
      end

      default: state_nxt = LOAD_HDR;
    endcase

    // Core runs only in RUN; registered so it moves on the same edge as the state.
    core_hold_nxt = (state_nxt != RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD_HDR;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_hold <= 1'b1;
      halted    <= 1'b0;
      cycles    <= '0;
      seg_count <= '0;
      wrap_err  <= 1'b0;
      remain    <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      core_hold <= core_hold_nxt;
      halted    <= halted_nxt;
      cycles    <= cycles_nxt;
      seg_count <= seg_count_nxt;
      wrap_err  <= wrap_err_nxt;
      remain    <= remain_nxt;
      ptr       <= ptr_nxt;
    end
  end

endmodule
